// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the MUL sequencer: FSM state encodings, MUL opcode and a counter-width helper.
package mul_sequencer_pkg;

  localparam logic [1:0] MUL_IDLE = 2'b00;
  localparam logic [1:0] MUL_BUSY = 2'b01;
  localparam logic [1:0] MUL_DONE = 2'b10;

  // LEGv8 R-format MUL opcode, as decoded by the control unit.
  localparam logic [10:0] MUL_OPCODE = 11'b100_1101_1000;

  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mul_sequencer_dp.sv
// Shift-add datapath: mcand/mplier/acc registers plus adder. One step per cycle while step is high.
// Backpressure: none; strobes from the controller are obeyed every cycle, clear beats load beats step.
module mul_sequencer_dp #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic             mplier_rest_zero
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (step) begin
      // Wraparound keeps only the low WIDTH bits, which is the same for signed and unsigned operands.
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // True when the multiplier will be all zero after this cycle's shift.
  assign mplier_rest_zero = ((mplier >> 1) == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Iterative radix-2 MUL unit: start accepted in IDLE, done pulse after WIDTH (or fewer with EARLY_EXIT) BUSY cycles.
// Backpressure: none; busy tells decode to hold the PC, and start is ignored until the IDLE cycle after DONE.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             multiplier_done,
  output logic             busy,
  output logic [WIDTH-1:0] product
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          dp_clear;
  logic          dp_load;
  logic          dp_step;
  logic          mplier_rest_zero;
  logic          finish;

  // abort outranks mult_start in IDLE and cancels work in BUSY; it has no effect in DONE.
  assign dp_load  = (state == MUL_IDLE) && mult_start && !abort;
  assign dp_step  = (state == MUL_BUSY) && !abort;
  assign dp_clear = (state == MUL_BUSY) && abort;
  assign finish   = (count == LAST_COUNT) || (EARLY_EXIT && mplier_rest_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUL_IDLE;
      count <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (dp_load) begin
            state <= MUL_BUSY;
            count <= '0;
          end
        end
        MUL_BUSY: begin
          if (abort) begin
            state <= MUL_IDLE;
            count <= '0;
          end else begin
            count <= count + CW'(1);
            if (finish) begin
              state <= MUL_DONE;
            end
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign multiplier_done = (state == MUL_DONE);
  assign busy            = (state == MUL_BUSY) || (state == MUL_DONE);

  mul_sequencer_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk              (clk),
    .reset            (reset),
    .clear            (dp_clear),
    .load             (dp_load),
    .step             (dp_step),
    .op_a             (op_a),
    .op_b             (op_b),
    .acc              (product),
    .mplier_rest_zero (mplier_rest_zero)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: one instance per EARLY_EXIT setting, directed and random multiplies vs a plain-arithmetic model.
module tb_mul_sequencer;

  localparam int W     = 64;
  localparam int LIMIT = 100;

  logic          clk;
  logic          reset      [2];
  logic          mult_start [2];
  logic          abort      [2];
  logic [W-1:0]  op_a       [2];
  logic [W-1:0]  op_b       [2];
  logic          done       [2];
  logic          busy       [2];
  logic [W-1:0]  product    [2];

  int tests;
  int fails;

  mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset[0]), .mult_start(mult_start[0]), .abort(abort[0]),
    .op_a(op_a[0]), .op_b(op_b[0]),
    .multiplier_done(done[0]), .busy(busy[0]), .product(product[0])
  );

  mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset[1]), .mult_start(mult_start[1]), .abort(abort[1]),
    .op_a(op_a[1]), .op_b(op_b[1]),
    .multiplier_done(done[1]), .busy(busy[1]), .product(product[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle of the done pulse, counting the cycle whose closing edge accepted the start as cycle 0.
  function automatic int model_done_cycle(input int d, input logic [W-1:0] b);
    int msb;
    int busy_len;
    if (d == 0) return W + 1;
    msb = -1;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    busy_len = (msb + 1 < 1) ? 1 : msb + 1;
    return busy_len + 1;
  endfunction

  task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    mult_start[d] = 1'b1;
    op_a[d] = a;
    op_b[d] = b;
    @(posedge clk);
  endtask

  // Called right after the start edge; returns at the negedge of the done cycle with mult_start still high.
  task automatic wait_done(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit scramble, input string tag);
    int got;
    int busy_ok;
    logic [W-1:0] exp_p;
    exp_p   = a * b;
    got     = -1;
    busy_ok = 1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (scramble) begin
        op_a[d] = {$urandom, $urandom};
        op_b[d] = {$urandom, $urandom};
      end
      if (busy[d] !== 1'b1) busy_ok = 0;
      if (done[d] === 1'b1) begin
        got = k;
        break;
      end
    end
    checki({tag, " done_cycle"}, got, model_done_cycle(d, b));
    check64({tag, " product"}, product[d], exp_p);
    checki({tag, " busy_span"}, busy_ok, 1);
  endtask

  task automatic mul_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble, input string tag);
    issue(d, a, b);
    wait_done(d, a, b, scramble, tag);
    mult_start[d] = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int pulses;
    tests = 0;
    fails = 0;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      mult_start[d] = 1'b0;
      abort[d] = 1'b0;
      op_a[d] = '0;
      op_b[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checki("reset busy", int'(busy[d]), 0);
      checki("reset done", int'(done[d]), 0);
      check64("reset product", product[d], '0);
      reset[d] = 1'b0;
    end

    // Full-length run, truncation and negative operand on the non-early-exit unit.
    mul_op(0, 64'd3, 64'd5, 1'b0, "ee0 3x5");
    mul_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, "ee0 trunc");
    mul_op(0, -64'sd7, 64'd6, 1'b0, "ee0 neg7x6");
    check64("neg7x6 literal", product[0], 64'hFFFF_FFFF_FFFF_FFD6);

    // Early-exit latency follows the highest set multiplier bit.
    mul_op(1, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, "ee1 b0");
    mul_op(1, 64'd11, 64'd5, 1'b0, "ee1 b5");
    mul_op(1, 64'd3, 64'h8000_0000_0000_0000, 1'b0, "ee1 bmsb");

    // Held start across two multiplies: exactly one IDLE cycle in between.
    issue(1, 64'd3, 64'd5);
    wait_done(1, 64'd3, 64'd5, 1'b0, "chain first");
    op_a[1] = 64'd7;
    op_b[1] = 64'd9;
    @(negedge clk);
    checki("chain idle gap", int'(busy[1]), 0);
    @(posedge clk);
    wait_done(1, 64'd7, 64'd9, 1'b1, "chain second");
    mult_start[1] = 1'b0;
    check64("chain 63", product[1], 64'd63);

    // Random operands, changed every BUSY cycle to prove sampling only at start.
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      mul_op(i % 2, ra, rb, 1'b1, "random");
    end

    // Reset during BUSY at cycle 10.
    issue(0, 64'hDEAD_BEEF_0000_1234, 64'hFFFF);
    repeat (10) @(negedge clk);
    reset[0] = 1'b1;
    mult_start[0] = 1'b0;
    @(negedge clk);
    checki("reset_busy busy", int'(busy[0]), 0);
    checki("reset_busy done", int'(done[0]), 0);
    check64("reset_busy product", product[0], '0);
    reset[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) pulses++;
    end
    checki("reset_busy no_done", pulses, 0);

    // Abort during BUSY on a long early-exit multiply.
    issue(1, 64'hF00D, 64'h8000_0000_0000_0003);
    repeat (5) @(negedge clk);
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    mult_start[1] = 1'b0;
    checki("abort_busy busy", int'(busy[1]), 0);
    check64("abort_busy product", product[1], '0);
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done[1] === 1'b1) pulses++;
    end
    checki("abort_busy no_done", pulses, 0);

    // Abort in DONE: the pulse already happened and the product survives.
    mul_op(1, 64'd13, 64'd5, 1'b0, "abort_done run");
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    checki("abort_done busy", int'(busy[1]), 0);
    check64("abort_done product", product[1], 64'd65);

    // abort + start in IDLE: no start, product holds.
    mult_start[1] = 1'b1;
    abort[1] = 1'b1;
    op_a[1] = 64'd2;
    op_b[1] = 64'd2;
    @(negedge clk);
    mult_start[1] = 1'b0;
    abort[1] = 1'b0;
    checki("abort_idle busy", int'(busy[1]), 0);
    check64("abort_idle product", product[1], 64'd65);
    @(negedge clk);
    checki("abort_idle stays", int'(busy[1]), 0);

    // reset + start in IDLE: stays IDLE.
    reset[1] = 1'b1;
    mult_start[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    mult_start[1] = 1'b0;
    checki("reset_idle busy", int'(busy[1]), 0);
    check64("reset_idle product", product[1], '0);
    @(negedge clk);
    checki("reset_idle stays", int'(busy[1]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
